// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 phase sequencer.
// Phase codes double as the S-memory grant select.
package arc4_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StInitGo,
    StInitWait,
    StKsaGo,
    StKsaWait,
    StPrgaGo,
    StPrgaWait,
    StFail
  } state_e;

  function automatic logic [1:0] state_phase(input state_e s);
    case (s)
      StInitGo, StInitWait: return PH_INIT;
      StKsaGo, StKsaWait:   return PH_KSA;
      StPrgaGo, StPrgaWait: return PH_PRGA;
      default:              return PH_IDLE;
    endcase
  endfunction

  function automatic logic state_is_go(input state_e s);
    return (s == StInitGo) || (s == StKsaGo) || (s == StPrgaGo);
  endfunction

  function automatic logic state_is_wait(input state_e s);
    return (s == StInitWait) || (s == StKsaWait) || (s == StPrgaWait);
  endfunction

endpackage

// File: rtl/s_mem_mux.sv
// Zero-latency S-memory port mux; grant 0 parks the port with writes disabled.
module s_mem_mux
  import arc4_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    unique case (sel)
      PH_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      PH_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PH_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_seq.sv
// Sequences the init, ksa and prga clients in order, owns the shared S-memory
// port, and aborts any phase that exceeds the watchdog limit.
module arc4_seq
  import arc4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  output logic        err,
  input  logic [23:0] key,
  output logic [23:0] key_q,
  output logic [1:0]  phase,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_wrdata,
  input  logic        init_wren,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  ksa_wrdata,
  input  logic        ksa_wren,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  prga_wrdata,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  localparam int unsigned WdW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  state_e         state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d, wd_inc;
  logic           busy_seen_q, busy_seen_d;
  logic           err_q, err_d;
  logic [23:0]    key_d;
  logic [1:0]     grant;
  logic           cur_rdy, in_phase, wd_expire, go_fire, done;

  assign grant     = state_phase(state_q);
  assign in_phase  = state_is_go(state_q) || state_is_wait(state_q);
  assign wd_inc    = wd_q + 1'b1;
  // The counter reaching its last value forces FAIL in the same edge, so it never wraps.
  assign wd_expire = in_phase && (wd_inc == WdLast);
  assign go_fire   = state_is_go(state_q) && cur_rdy && !wd_expire;
  // A rdy still high right after the start pulse is not completion.
  assign done      = state_is_wait(state_q) && cur_rdy && busy_seen_q;

  always_comb begin
    unique case (grant)
      PH_INIT: cur_rdy = init_rdy;
      PH_KSA:  cur_rdy = ksa_rdy;
      PH_PRGA: cur_rdy = prga_rdy;
      default: cur_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      busy_seen_q <= 1'b0;
      err_q       <= 1'b0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      busy_seen_q <= busy_seen_d;
      err_q       <= err_d;
      key_q       <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (en) state_d = StInitGo;
      StInitGo:   if (go_fire) state_d = StInitWait;
      StInitWait: if (done) state_d = StKsaGo;
      StKsaGo:    if (go_fire) state_d = StKsaWait;
      StKsaWait:  if (done) state_d = StPrgaGo;
      StPrgaGo:   if (go_fire) state_d = StPrgaWait;
      StPrgaWait: if (done) state_d = StIdle;
      StFail:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (wd_expire) state_d = StFail;
  end

  always_comb begin
    key_d = key_q;
    err_d = err_q;
    if (state_q == StIdle && en) begin
      key_d = key;
      err_d = 1'b0;
    end
    if (state_d == StFail) err_d = 1'b1;

    busy_seen_d = state_is_wait(state_q) ? (busy_seen_q || !cur_rdy) : 1'b0;

    if (state_is_go(state_d) && (state_d != state_q)) begin
      wd_d = '0;
    end else if (in_phase) begin
      wd_d = wd_inc;
    end else begin
      wd_d = '0;
    end
  end

  always_comb begin
    rdy     = (state_q == StIdle);
    init_en = go_fire && (grant == PH_INIT);
    ksa_en  = go_fire && (grant == PH_KSA);
    prga_en = go_fire && (grant == PH_PRGA);
    phase   = grant;
    err     = err_q;
  end

  s_mem_mux u_s_mem_mux (
    .sel         (grant),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: behavioural client stubs plus a timeline model that predicts
// phase, start pulses, rdy/err and the S-port for every cycle of a run.
module tb_arc4_seq;
  import arc4_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] key = '0;
  logic        use_wd = 1'b0;

  logic [7:0] c_addr[3];
  logic [7:0] c_wdat[3];
  logic       c_wren[3];
  logic [2:0] c_rdy = 3'b111;

  int cfg_late[3];
  int cfg_busy[3];
  bit stuck[3];
  int late_left[3];
  int busy_left[3];

  int n_total = 0;
  int n_bad   = 0;

  wire        d_rdy, d_err, d_s_wren, w_rdy, w_err, w_s_wren;
  wire [23:0] d_key_q, w_key_q;
  wire [1:0]  d_phase, w_phase;
  wire [2:0]  d_en, w_en;
  wire [7:0]  d_s_addr, d_s_wrdata, w_s_addr, w_s_wrdata;

  wire        m_rdy   = use_wd ? w_rdy : d_rdy;
  wire        m_err   = use_wd ? w_err : d_err;
  wire [23:0] m_key_q = use_wd ? w_key_q : d_key_q;
  wire [1:0]  m_phase = use_wd ? w_phase : d_phase;
  wire [2:0]  m_en    = use_wd ? w_en : d_en;
  wire [16:0] m_sport = use_wd ? {w_s_addr, w_s_wrdata, w_s_wren}
                               : {d_s_addr, d_s_wrdata, d_s_wren};

  always #5 clk = ~clk;

  arc4_seq dut (
    .clk(clk), .rst(rst), .en(en), .rdy(d_rdy), .err(d_err), .key(key), .key_q(d_key_q),
    .phase(d_phase), .init_en(d_en[0]), .ksa_en(d_en[1]), .prga_en(d_en[2]),
    .init_rdy(c_rdy[0]), .ksa_rdy(c_rdy[1]), .prga_rdy(c_rdy[2]),
    .init_addr(c_addr[0]), .init_wrdata(c_wdat[0]), .init_wren(c_wren[0]),
    .ksa_addr(c_addr[1]), .ksa_wrdata(c_wdat[1]), .ksa_wren(c_wren[1]),
    .prga_addr(c_addr[2]), .prga_wrdata(c_wdat[2]), .prga_wren(c_wren[2]),
    .s_addr(d_s_addr), .s_wrdata(d_s_wrdata), .s_wren(d_s_wren)
  );

  arc4_seq #(.TIMEOUT_CYC(64)) dut_wd (
    .clk(clk), .rst(rst), .en(en), .rdy(w_rdy), .err(w_err), .key(key), .key_q(w_key_q),
    .phase(w_phase), .init_en(w_en[0]), .ksa_en(w_en[1]), .prga_en(w_en[2]),
    .init_rdy(c_rdy[0]), .ksa_rdy(c_rdy[1]), .prga_rdy(c_rdy[2]),
    .init_addr(c_addr[0]), .init_wrdata(c_wdat[0]), .init_wren(c_wren[0]),
    .ksa_addr(c_addr[1]), .ksa_wrdata(c_wdat[1]), .ksa_wren(c_wren[1]),
    .prga_addr(c_addr[2]), .prga_wrdata(c_wdat[2]), .prga_wren(c_wren[2]),
    .s_addr(w_s_addr), .s_wrdata(w_s_wrdata), .s_wren(w_s_wren)
  );

  // Client stub: after a start pulse, rdy stays high for cfg_late cycles,
  // low for cfg_busy cycles, then high again.
  always @(posedge clk) begin : stubs
    int nl, nb;
    for (int i = 0; i < 3; i++) begin
      nl = late_left[i];
      nb = busy_left[i];
      if (rst) begin
        nl = 0;
        nb = 0;
      end else if (m_en[i]) begin
        nl = cfg_late[i];
        nb = cfg_busy[i];
      end else if (nl > 0) begin
        nl--;
      end else if (nb > 0) begin
        nb--;
      end
      late_left[i] <= nl;
      busy_left[i] <= nb;
      c_rdy[i]     <= !stuck[i] && (nl > 0 || nb == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive_clients(input bit arb);
    for (int i = 0; i < 3; i++) begin
      c_addr[i] = 8'($urandom);
      c_wdat[i] = 8'($urandom);
      c_wren[i] = 1'($urandom);
    end
    if (arb) begin
      c_addr[1] = 8'hAA;
      c_wren[1] = 1'b1;
    end
  endtask

  function automatic logic [16:0] sport_exp(input logic [1:0] ph);
    case (ph)
      PH_INIT: return {c_addr[0], c_wdat[0], c_wren[0]};
      PH_KSA:  return {c_addr[1], c_wdat[1], c_wren[1]};
      PH_PRGA: return {c_addr[2], c_wdat[2], c_wren[2]};
      default: return '0;
    endcase
  endfunction

  task automatic check_idle_reset(input string tag);
    check({tag, ".rdy"}, 32'(m_rdy), 32'd1);
    check({tag, ".err"}, 32'(m_err), 32'd0);
    check({tag, ".key_q"}, 32'(m_key_q), 32'd0);
    check({tag, ".phase"}, 32'(m_phase), 32'(PH_IDLE));
    check({tag, ".en"}, 32'(m_en), 32'd0);
    check({tag, ".sport"}, 32'(m_sport), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    en  = 1'b0;
    drive_clients(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_clients(1'b0);
    @(negedge clk);
  endtask

  // One run from en acceptance (cycle 0) through a few idle cycles. Each phase lasts
  // late+busy+2 cycles; a stuck ksa instead enters FAIL at KSA cycle tmo-1.
  task automatic run_seq(input int b0, input int b1, input int b2,
                         input int l0, input int l1, input int l2,
                         input logic [23:0] k, input bit ign, input bit arb,
                         input bit stk, input int tmo, input int rst_ksa);
    int g1, g2, g3, end_c, last, rst_c;
    logic [1:0] ph;
    logic [2:0] exp_en;
    logic exp_rdy, exp_err;
    cfg_busy[0] = b0; cfg_busy[1] = b1; cfg_busy[2] = b2;
    cfg_late[0] = l0; cfg_late[1] = l1; cfg_late[2] = l2;
    stuck[1] = stk;
    g1 = 1;
    g2 = g1 + l0 + b0 + 2;
    g3 = g2 + l1 + b1 + 2;
    end_c = g3 + l2 + b2 + 1;
    last = stk ? g2 + tmo - 1 : end_c;
    rst_c = (rst_ksa >= 0) ? g2 + rst_ksa : -1;
    for (int c = 0; c <= last + 3; c++) begin
      @(posedge clk); #1;
      rst = (c == rst_c);
      en  = (c == 0) || (ign && c <= last && rst_c < 0 && $urandom_range(3) == 0);
      key = (c == 0) ? k : (en ? 24'hFFFFFF : 24'($urandom));
      drive_clients(arb);
      @(negedge clk);
      if (rst_c >= 0 && c == rst_c + 1) begin
        check_idle_reset($sformatf("midrst@%0d", c));
        break;
      end
      if (c < g1) ph = PH_IDLE;
      else if (c < g2) ph = PH_INIT;
      else if (stk) ph = (c < g2 + tmo - 1) ? PH_KSA : PH_IDLE;
      else if (c < g3) ph = PH_KSA;
      else if (c <= end_c) ph = PH_PRGA;
      else ph = PH_IDLE;
      exp_en  = {(!stk && c == g3), (!stk && c == g2), (c == g1)};
      exp_rdy = (c == 0) || (c > last);
      exp_err = stk && (c >= last);
      check($sformatf("phase@%0d", c), 32'(m_phase), 32'(ph));
      check($sformatf("x_en@%0d", c), 32'(m_en), 32'(exp_en));
      check($sformatf("rdy@%0d", c), 32'(m_rdy), 32'(exp_rdy));
      check($sformatf("sport@%0d", c), 32'(m_sport), 32'(sport_exp(ph)));
      if (c >= 1) begin
        check($sformatf("key_q@%0d", c), 32'(m_key_q), 32'(k));
        check($sformatf("err@%0d", c), 32'(m_err), 32'(exp_err));
      end
    end
    stuck[1] = 1'b0;
    rst = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cfg_late[i] = 0;
      cfg_busy[i] = 1;
      stuck[i]    = 1'b0;
      late_left[i] = 0;
      busy_left[i] = 0;
    end
    drive_clients(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_reset("reset");
    use_wd = 1'b1;
    check_idle_reset("reset_wd");
    use_wd = 1'b0;

    // rst beats en in the same cycle
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1; key = 24'h123456;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    check_idle_reset("rst_vs_en");

    run_seq(256, 768, 20, 0, 0, 0, 24'h00033C, 1'b0, 1'b0, 1'b0, 0, -1);
    run_seq(10, 12, 5, 0, 0, 0, 24'($urandom), 1'b0, 1'b1, 1'b0, 0, -1);
    run_seq(5, 6, 7, 0, 0, 3, 24'($urandom), 1'b0, 1'b0, 1'b0, 0, -1);
    run_seq(8, 9, 40, 1, 2, 0, 24'h0A0B0C, 1'b1, 1'b0, 1'b0, 0, -1);
    run_seq(6, 30, 6, 0, 0, 0, 24'h5A5A5A, 1'b0, 1'b0, 1'b0, 0, 7);
    run_seq(4, 4, 4, 0, 0, 0, 24'h00BEEF, 1'b0, 1'b0, 1'b0, 0, -1);
    for (int r = 0; r < 6; r++) begin
      run_seq($urandom_range(40, 1), $urandom_range(40, 1), $urandom_range(40, 1),
              $urandom_range(3), $urandom_range(3), $urandom_range(3),
              24'($urandom), 1'($urandom), 1'($urandom), 1'b0, 0, -1);
    end

    // Watchdog on the 64-cycle instance, then err clears on reset and on a new run.
    use_wd = 1'b1;
    do_reset();
    check_idle_reset("wd_reset");
    run_seq(10, 5, 5, 0, 0, 0, 24'h00033C, 1'b0, 1'b0, 1'b1, 64, -1);
    do_reset();
    check_idle_reset("err_rst");
    run_seq(10, 5, 5, 0, 0, 0, 24'h112233, 1'b0, 1'b0, 1'b1, 64, -1);
    run_seq(5, 5, 5, 0, 1, 0, 24'h445566, 1'b0, 1'b0, 1'b0, 0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/arc4_seq.md
ARC4_SEQ -- requirements
Module: arc4_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096, per-phase watchdog limit in clk cycles.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 en  in  1  start request; sampled only when rdy=1.
REQ-005 rdy  out  1  high = idle and able to accept en.
REQ-006 err  out  1  high = last run aborted by watchdog.
REQ-007 key  in  24  cipher key, latched on accepted en.
REQ-008 key_q  out  24  latched key, driven to ksa and prga.
REQ-009 phase  out  2  0 idle, 1 init, 2 ksa, 3 prga.
REQ-010 {init,ksa,prga}_en  out  1 each  one-cycle start pulse to each client.
REQ-011 {init,ksa,prga}_rdy  in  1 each  client ready, same en/rdy protocol as this block.
REQ-012 {init,ksa,prga}_addr / _wrdata / _wren  in  8/8/1 each  client S-memory requests.
REQ-013 s_addr / s_wrdata / s_wren  out  8/8/1  shared S-memory port; s_rddata is wired directly to the clients, not through this block.

Function
REQ-014 The handshake SHALL be: en is accepted only in a cycle with rdy=1; rdy=0 from the following cycle until completion; en while rdy=0 is ignored.
REQ-015 The FSM states SHALL be IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, FAIL.
REQ-016 IDLE: rdy=1; an accepted en latches key_q, clears err, and moves to INIT_GO.
REQ-017 X_GO: the FSM SHALL wait for x_rdy=1, then assert x_en for exactly that one cycle and move to X_WAIT.
REQ-018 X_WAIT: a busy_seen flag SHALL set on x_rdy=0; the phase SHALL complete only on x_rdy=1 with busy_seen=1, so a rdy that stays high in the cycle after en is never taken as completion.
REQ-019 Phase order SHALL be INIT_WAIT done -> KSA_GO, KSA_WAIT done -> PRGA_GO, PRGA_WAIT done -> IDLE, with rdy=1 in the IDLE cycle.
REQ-020 A watchdog counter SHALL clear on entry to every GO state and increment each cycle in GO/WAIT; reaching TIMEOUT_CYC-1 SHALL force FAIL.
REQ-021 FAIL: err=1, all x_en=0, s_wren=0, one cycle, then IDLE; err SHALL hold until the next accepted en or rst.
REQ-022 The S-port mux SHALL be combinational with zero latency: INIT_* grants init, KSA_* grants ksa, PRGA_* grants prga, IDLE/FAIL drives s_addr=0, s_wrdata=0, s_wren=0.
REQ-023 A non-granted client's wren SHALL never reach s_wren.
REQ-024 phase SHALL reflect the granted client (0 in IDLE/FAIL).
REQ-025 key_q SHALL remain stable for the whole run, independent of key changes.
REQ-026 The watchdog SHALL be at least clog2(TIMEOUT_CYC) bits wide and SHALL not wrap.

Reset
REQ-027 rst=1 at any clock edge SHALL force IDLE, rdy=1, err=0, key_q=0, all x_en=0, busy_seen=0, and clear the watchdog.
REQ-028 Reset mid-run SHALL abort without completion; the next en SHALL restart from INIT_GO.
REQ-029 rst SHALL take priority over en in the same cycle.

Structure
REQ-030 The state enum, phase encodings (PH_IDLE..PH_PRGA) and default TIMEOUT_CYC SHALL live in package arc4_pkg.
REQ-031 The combinational S-port mux SHALL be the single sub-module s_mem_mux, with inputs for three clients and a 2-bit grant select.
REQ-032 Total RTL SHALL be roughly 150-300 lines.

Verification
REQ-033 Normal run: stub clients each busy for 256/768/20 cycles, key=24'h00033C, en pulse -> init_en, ksa_en and prga_en each pulse once in order; rdy returns 1 after all three, err=0, key_q=24'h00033C.
REQ-034 Arbitration: ksa drives wren=1, addr=8'hAA throughout the INIT phase -> s_wren follows init only; s_addr=8'hAA appears only during KSA_*.
REQ-035 Late rdy: prga_rdy held high for 3 cycles after prga_en -> no early completion; completion only after prga_rdy goes 0 then 1.
REQ-036 Timeout: TIMEOUT_CYC=64, ksa_rdy stuck at 0 -> FAIL at cycle 63 of the KSA phase; err=1, rdy=1 next cycle; prga_en never pulses.
REQ-037 Reset mid-KSA: rst=1 for one cycle -> IDLE, rdy=1, err=0, key_q=0; a new en restarts with init_en.
REQ-038 Ignored en: en pulses during the PRGA phase with key=24'hFFFFFF -> key_q unchanged, no extra x_en pulses.
